debug_halt_ctrl: RTL and testbench

DEBUG_HALT_CTRL -- requirements
Module: debug_halt_ctrl

---
 rtl/debug_pkg.sv | 20 ++
 rtl/drain_monitor.sv | 53 +++++
 rtl/debug_halt_ctrl.sv | 101 ++++++++++
 tb/tb_debug_halt_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared debug halt types and instruction constants
package debug_pkg;

    typedef enum logic [2:0] {
        ST_RUNNING = 3'd0,
        ST_DRAIN   = 3'd1,
        ST_FLUSH   = 3'd2,
        ST_HALTED  = 3'd3,
        ST_RESUME  = 3'd4,
        ST_STEP    = 3'd5
    } dbg_state_t;

    // Injected into stage 2 while halt_active_o is high
    localparam logic [31:0] NOP_INSN    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

    // Byte distance to the next sequential instruction
    localparam logic [31:0] INSN_BYTES  = 32'd4;

endpackage

// File: rtl/drain_monitor.sv
// rtl/drain_monitor.sv - consecutive-empty and timeout counters for the drain phase
module drain_monitor #(
    parameter int DRAIN_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic start_i,
    input  logic inst_comp_i,
    output logic done_o,
    output logic timeout_o
);

    localparam int CW = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CW:0]   CYC_LIM = (CW + 1)'(DRAIN_CYCLES);
    localparam logic [CW:0]   TO_LIM  = (CW + 1)'(DRAIN_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [CW-1:0] consec_q, consec_d;
    logic [CW-1:0] total_q, total_d;
    logic [CW:0]   consec_nxt, total_nxt;

    // Counts including the current cycle; one bit wider so the compare never wraps
    assign consec_nxt = {1'b0, consec_q} + 1'b1;
    assign total_nxt  = {1'b0, total_q} + 1'b1;

    // start_i is high for the whole drain; counters sit at zero otherwise so every entry starts clean
    always_comb begin
        consec_d = '0;
        total_d  = '0;
        if (start_i) begin
            total_d = (total_q == CNT_MAX) ? total_q : total_q + 1'b1;
            if (inst_comp_i) begin
                consec_d = (consec_q == CNT_MAX) ? consec_q : consec_q + 1'b1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            consec_q <= '0;
            total_q  <= '0;
        end else begin
            consec_q <= consec_d;
            total_q  <= total_d;
        end
    end

    assign done_o    = start_i & inst_comp_i & (consec_nxt >= CYC_LIM);
    assign timeout_o = start_i & (total_nxt >= TO_LIM);

endmodule

// File: rtl/debug_halt_ctrl.sv
// rtl/debug_halt_ctrl.sv - debug halt/resume/single-step sequencer
module debug_halt_ctrl
    import debug_pkg::*;
#(
    parameter int DRAIN_CYCLES  = 2,
    parameter int DRAIN_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        haltreq_i,
    input  logic        resumereq_i,
    input  logic        step_i,
    input  logic        inst_comp_i,
    input  logic [31:0] pc_i,
    output logic        halt_active_o,
    output logic        reset_stages_o,
    output logic        halted_o,
    output logic        resume_ack_o,
    output logic [31:0] dpc_o,
    output logic        drain_err_o
);

    dbg_state_t  state_q, state_d;
    logic [31:0] dpc_q, dpc_d;
    logic        drain_err_q, drain_err_d;
    logic        drain_done, drain_timeout;

    drain_monitor #(
        .DRAIN_CYCLES  (DRAIN_CYCLES),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT)
    ) u_drain_monitor (
        .clk         (clk),
        .reset       (reset),
        .start_i     (state_q == ST_DRAIN),
        .inst_comp_i (inst_comp_i),
        .done_o      (drain_done),
        .timeout_o   (drain_timeout)
    );

    // Next-state, captured PC and sticky timeout flag
    always_comb begin
        state_d     = state_q;
        dpc_d       = dpc_q;
        drain_err_d = drain_err_q;
        unique case (state_q)
            ST_RUNNING: begin
                if (haltreq_i) begin
                    state_d = ST_DRAIN;
                    dpc_d   = pc_i;
                end
            end
            ST_DRAIN: begin
                // Timeout wins: if both fire together the flag is still raised
                if (drain_timeout) begin
                    state_d     = ST_FLUSH;
                    drain_err_d = 1'b1;
                end else if (drain_done) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: state_d = ST_HALTED;
            ST_HALTED: begin
                if (resumereq_i) begin
                    state_d = step_i ? ST_STEP : ST_RESUME;
                end
            end
            ST_RESUME: state_d = ST_RUNNING;
            ST_STEP: begin
                // The single stepped instruction retires; halt again after it
                state_d = ST_DRAIN;
                dpc_d   = pc_i + INSN_BYTES;
            end
            default: state_d = ST_RUNNING;
        endcase
    end

    // State, DPC and error registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUNNING;
            dpc_q       <= '0;
            drain_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dpc_q       <= dpc_d;
            drain_err_q <= drain_err_d;
        end
    end

    // Output decode from the state register only
    always_comb begin
        halt_active_o  = (state_q == ST_DRAIN) || (state_q == ST_FLUSH) || (state_q == ST_HALTED);
        reset_stages_o = (state_q == ST_FLUSH);
        halted_o       = (state_q == ST_HALTED);
        resume_ack_o   = (state_q == ST_RESUME) || (state_q == ST_STEP);
    end

    assign dpc_o       = dpc_q;
    assign drain_err_o = drain_err_q;

endmodule

// File: tb/tb_debug_halt_ctrl.sv
// tb/tb_debug_halt_ctrl.sv - scoreboard bench for debug_halt_ctrl
module tb_debug_halt_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        haltreq_i, resumereq_i, step_i, inst_comp_i;
    logic [31:0] pc_i;
    logic        halt_active_o, reset_stages_o, halted_o, resume_ack_o, drain_err_o;
    logic [31:0] dpc_o;

    int err_cnt = 0;
    int chk_cnt = 0;

    typedef struct {
        string       tag;
        logic [4:0]  flags;
        logic [31:0] dpc;
    } exp_t;

    exp_t exp_q[$];

    // flag order: halt_active, reset_stages, halted, resume_ack, drain_err
    localparam logic [4:0] F_RUN   = 5'b00000;
    localparam logic [4:0] F_DRAIN = 5'b10000;
    localparam logic [4:0] F_FLUSH = 5'b11000;
    localparam logic [4:0] F_HALT  = 5'b10100;
    localparam logic [4:0] F_ACK   = 5'b00010;
    localparam logic [4:0] F_ERR   = 5'b00001;

    debug_halt_ctrl #(
        .DRAIN_CYCLES  (2),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .haltreq_i      (haltreq_i),
        .resumereq_i    (resumereq_i),
        .step_i         (step_i),
        .inst_comp_i    (inst_comp_i),
        .pc_i           (pc_i),
        .halt_active_o  (halt_active_o),
        .reset_stages_o (reset_stages_o),
        .halted_o       (halted_o),
        .resume_ack_o   (resume_ack_o),
        .dpc_o          (dpc_o),
        .drain_err_o    (drain_err_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] obs_flags();
        return {halt_active_o, reset_stages_o, halted_o, resume_ack_o, drain_err_o};
    endfunction

    // Drive one cycle of inputs, queue what must appear after the edge, then compare
    task automatic cyc(input string tag, input logic h, input logic r, input logic s,
                       input logic c, input logic [31:0] pc,
                       input logic [4:0] ef, input logic [31:0] ed);
        exp_t e;
        haltreq_i   = h;
        resumereq_i = r;
        step_i      = s;
        inst_comp_i = c;
        pc_i        = pc;
        exp_q.push_back('{tag, ef, ed});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq({e.tag, "_flags"}, {27'd0, obs_flags()}, {27'd0, e.flags});
            check_eq({e.tag, "_dpc"}, dpc_o, e.dpc);
        end
    endtask

    initial begin
        reset       = 1'b0;
        haltreq_i   = 1'b0;
        resumereq_i = 1'b0;
        step_i      = 1'b0;
        inst_comp_i = 1'b0;
        pc_i        = 32'h0;
        #3;
        check_eq("rst_flags", {27'd0, obs_flags()}, 32'd0);
        check_eq("rst_dpc", dpc_o, 32'd0);
        #9 reset = 1'b1;

        cyc("idle", 0, 0, 0, 0, 32'h3c, F_RUN, 32'h0);

        // Halt entry with the pipeline already empty
        cyc("h_enter", 1, 0, 0, 0, 32'h40, F_DRAIN, 32'h40);
        cyc("h_d1",    1, 0, 0, 1, 32'h44, F_DRAIN, 32'h40);
        cyc("h_d2",    1, 0, 0, 1, 32'h44, F_FLUSH, 32'h40);
        cyc("h_fl",    1, 0, 0, 1, 32'h44, F_HALT,  32'h40);
        cyc("h_hold",  1, 0, 0, 1, 32'h44, F_HALT,  32'h40);

        // Single step from halted
        cyc("s_req",   0, 1, 1, 0, 32'h80, F_ACK,   32'h40);
        cyc("s_fetch", 0, 0, 0, 0, 32'h80, F_DRAIN, 32'h84);
        cyc("s_d1",    0, 0, 0, 1, 32'h84, F_DRAIN, 32'h84);
        cyc("s_d2",    0, 0, 0, 1, 32'h84, F_FLUSH, 32'h84);
        cyc("s_fl",    0, 0, 0, 0, 32'h84, F_HALT,  32'h84);

        // Plain resume, then stray resume/step requests while running
        cyc("r_req",   0, 1, 0, 0, 32'h84, F_ACK,   32'h84);
        cyc("r_run",   0, 0, 0, 0, 32'h88, F_RUN,   32'h84);
        cyc("r_ign",   0, 1, 1, 0, 32'h8c, F_RUN,   32'h84);

        // Drain glitch restarts the consecutive count
        cyc("g_enter", 1, 0, 0, 0, 32'h100, F_DRAIN, 32'h100);
        cyc("g_c1",    1, 0, 0, 1, 32'h104, F_DRAIN, 32'h100);
        cyc("g_c0",    1, 0, 0, 0, 32'h104, F_DRAIN, 32'h100);
        cyc("g_c1b",   1, 0, 0, 1, 32'h104, F_DRAIN, 32'h100);
        cyc("g_c1c",   1, 1, 0, 1, 32'h104, F_FLUSH, 32'h100);
        cyc("g_fl",    1, 0, 0, 0, 32'h104, F_HALT,  32'h100);

        // Resume with haltreq still high re-enters drain via one running cycle
        cyc("l_req",   1, 1, 0, 0, 32'h104, F_ACK,   32'h100);
        cyc("l_run",   1, 0, 0, 0, 32'h200, F_RUN,   32'h100);
        cyc("l_enter", 1, 0, 0, 0, 32'h200, F_DRAIN, 32'h200);

        // Timeout: 16th drain cycle also completes a pair, timeout must still flag
        for (int k = 1; k <= 14; k++) begin
            cyc($sformatf("t_d%0d", k), 1, 0, 0, 0, 32'h204, F_DRAIN, 32'h200);
        end
        cyc("t_d15",   1, 0, 0, 1, 32'h204, F_DRAIN, 32'h200);
        cyc("t_d16",   1, 0, 0, 1, 32'h204, F_FLUSH | F_ERR, 32'h200);
        cyc("t_fl",    0, 0, 0, 0, 32'h204, F_HALT | F_ERR,  32'h200);
        cyc("t_res",   0, 1, 0, 0, 32'h204, F_ACK | F_ERR,   32'h200);
        cyc("t_run",   0, 0, 0, 0, 32'h208, F_RUN | F_ERR,   32'h200);

        // Reset asserted while in FLUSH
        cyc("m_enter", 1, 0, 0, 0, 32'h300, F_DRAIN | F_ERR, 32'h300);
        cyc("m_d1",    1, 0, 0, 1, 32'h304, F_DRAIN | F_ERR, 32'h300);
        cyc("m_d2",    1, 0, 0, 1, 32'h304, F_FLUSH | F_ERR, 32'h300);
        reset = 1'b0;
        #1;
        check_eq("m_async_flags", {27'd0, obs_flags()}, 32'd0);
        check_eq("m_async_dpc", dpc_o, 32'd0);
        haltreq_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc("m_rel1",  0, 0, 0, 0, 32'h308, F_RUN, 32'h0);
        cyc("m_rel2",  0, 0, 0, 0, 32'h30c, F_RUN, 32'h0);

        check_eq("sb_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
